// File: rtl/rvvi_trace_packer_if.sv
`default_nettype none
// rvvi_trace_packer_if -- 32-bit word stream from the retire-trace packer to the TX framer.
// Rev 1.0
interface rvvi_trace_packer_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/rvvi_trace_packer.sv
`default_nettype none
// rvvi_trace_packer -- RVVI retire-trace capture, CSR delta compression, event FIFO and word serialiser.
// Rev 1.0
module rvvi_trace_packer #(
  parameter int XLEN         = 64,
  parameter int TOTAL_CSRS   = 36,
  parameter int MAX_CSRS     = 5,
  parameter int DEPTH        = 8,
  parameter int STALL_LEVEL  = 6,
  parameter int PACKET_DELAY = 2
) (
  input  wire                       clk,
  input  wire                       resetn,
  input  wire                       RetireValid,
  input  wire [XLEN-1:0]            PC,
  input  wire [31:0]                Instr,
  input  wire [63:0]                Mcycle,
  input  wire [63:0]                Minstret,
  input  wire                       Trap,
  input  wire [1:0]                 Priv,
  input  wire                       GPRWen,
  input  wire                       FPRWen,
  input  wire [4:0]                 GPRAddr,
  input  wire [4:0]                 FPRAddr,
  input  wire [XLEN-1:0]            GPRValue,
  input  wire [XLEN-1:0]            FPRValue,
  input  wire [TOTAL_CSRS*XLEN-1:0] CsrFlat,
  rvvi_trace_packer_if.master       tx,
  output logic                      ExternalStall,
  output logic                      Overflow,
  output logic [15:0]               CsrDeferCount,
  output logic [31:0]               TxPacketCount
);
  localparam int P    = XLEN / 32;
  localparam int IW   = (TOTAL_CSRS > 1) ? $clog2(TOTAL_CSRS) : 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int MAXN = 6 + 3 * P + MAX_CSRS * (1 + P);
  localparam int NW   = $clog2(MAXN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [XLEN-1:0]  r_shadow [TOTAL_CSRS];
  logic [31:0]      r_m_hdr  [DEPTH];
  logic [XLEN-1:0]  r_m_pc   [DEPTH];
  logic [31:0]      r_m_ins  [DEPTH];
  logic [63:0]      r_m_mcyc [DEPTH];
  logic [63:0]      r_m_mins [DEPTH];
  logic [XLEN-1:0]  r_m_gval [DEPTH];
  logic [XLEN-1:0]  r_m_fval [DEPTH];
  logic [IW-1:0]    r_m_cidx [DEPTH][MAX_CSRS];
  logic [XLEN-1:0]  r_m_cval [DEPTH][MAX_CSRS];

  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic [1:0]       r_state, w_next;
  logic [NW-1:0]    r_widx;
  logic [7:0]       r_gap;

  logic [3:0]       w_sel_cnt;
  logic [IW-1:0]    w_sel_idx [MAX_CSRS];
  logic [XLEN-1:0]  w_sel_val [MAX_CSRS];
  logic [TOTAL_CSRS-1:0] w_sel_mask;
  logic             w_defer;
  logic             w_push, w_pop, w_last;
  logic [31:0]      w_hdr_new, w_hd, w_word;
  int               w_len;

  // Lowest-indexed changed CSRs win; anything past MAX_CSRS stays pending in the shadow.
  always_comb begin
    w_sel_cnt  = '0;
    w_sel_mask = '0;
    w_defer    = 1'b0;
    for (int k = 0; k < MAX_CSRS; k++) begin
      w_sel_idx[k] = '0;
      w_sel_val[k] = '0;
    end
    for (int i = 0; i < TOTAL_CSRS; i++) begin
      if (CsrFlat[i*XLEN +: XLEN] != r_shadow[i]) begin
        if (w_sel_cnt == 4'(MAX_CSRS)) begin
          w_defer = 1'b1;
        end else begin
          for (int k = 0; k < MAX_CSRS; k++) begin
            if (k == int'(w_sel_cnt)) begin
              w_sel_idx[k] = IW'(i);
              w_sel_val[k] = CsrFlat[i*XLEN +: XLEN];
            end
          end
          w_sel_mask[i] = 1'b1;
          w_sel_cnt     = w_sel_cnt + 4'd1;
        end
      end
    end
  end

  assign w_hdr_new = {8'h5A, w_sel_cnt, Priv, Trap, GPRWen, FPRWen, GPRAddr, FPRAddr, 5'd0};
  // A pop in the same cycle never frees a slot for a push against a full FIFO.
  assign w_push = RetireValid && (r_count < CW'(DEPTH));
  assign w_pop  = (r_state == S_SEND) && tx.tready && w_last;
  assign ExternalStall = (r_count >= CW'(STALL_LEVEL));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_m_hdr[r_wptr]  <= w_hdr_new;
      r_m_pc[r_wptr]   <= PC;
      r_m_ins[r_wptr]  <= Instr;
      r_m_mcyc[r_wptr] <= Mcycle;
      r_m_mins[r_wptr] <= Minstret;
      r_m_gval[r_wptr] <= GPRValue;
      r_m_fval[r_wptr] <= FPRValue;
      for (int k = 0; k < MAX_CSRS; k++) begin
        r_m_cidx[r_wptr][k] <= w_sel_idx[k];
        r_m_cval[r_wptr][k] <= w_sel_val[k];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      Overflow      <= 1'b0;
      CsrDeferCount <= '0;
      TxPacketCount <= '0;
      for (int i = 0; i < TOTAL_CSRS; i++) r_shadow[i] <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      if (RetireValid && !w_push) Overflow <= 1'b1;
      if (w_push && w_defer && (CsrDeferCount != 16'hFFFF)) CsrDeferCount <= CsrDeferCount + 16'd1;
      if (w_pop) TxPacketCount <= TxPacketCount + 32'd1;
      for (int i = 0; i < TOTAL_CSRS; i++) begin
        if (w_push && w_sel_mask[i]) r_shadow[i] <= CsrFlat[i*XLEN +: XLEN];
      end
    end
  end

  function automatic logic [31:0] f_word(input logic [XLEN-1:0] v, input int w);
    f_word = v[31:0];
    for (int j = 1; j < P; j++) if (j == w) f_word = v[j*32 +: 32];
  endfunction

  assign w_hd   = r_m_hdr[r_rptr];
  assign w_len  = 6 + P + (int'(w_hd[16]) + int'(w_hd[15])) * P + int'(w_hd[23:20]) * (1 + P);
  assign w_last = (int'(r_widx) == w_len - 1);

  always_comb begin : p_word_mux
    int idx, rem, g, f, k, j;
    idx    = int'(r_widx);
    g      = w_hd[16] ? P : 0;
    f      = w_hd[15] ? P : 0;
    rem    = 0;
    k      = 0;
    j      = 0;
    w_word = '0;
    if (idx == 0)          w_word = w_hd;
    else if (idx <= P)     w_word = f_word(r_m_pc[r_rptr], idx - 1);
    else if (idx == P + 1) w_word = r_m_ins[r_rptr];
    else if (idx < P + 4)  w_word = (idx == P + 2) ? r_m_mcyc[r_rptr][31:0] : r_m_mcyc[r_rptr][63:32];
    else if (idx < P + 6)  w_word = (idx == P + 4) ? r_m_mins[r_rptr][31:0] : r_m_mins[r_rptr][63:32];
    else begin
      rem = idx - (P + 6);
      if (rem < g)          w_word = f_word(r_m_gval[r_rptr], rem);
      else if (rem < g + f) w_word = f_word(r_m_fval[r_rptr], rem - g);
      else begin
        rem = rem - g - f;
        k   = rem / (P + 1);
        j   = rem % (P + 1);
        for (int c = 0; c < MAX_CSRS; c++) begin
          if (c == k) w_word = (j == 0) ? {{(32-IW){1'b0}}, r_m_cidx[r_rptr][c]}
                                        : f_word(r_m_cval[r_rptr][c], j - 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // The gap exits straight into SEND when work is queued so the idle run is exactly PACKET_DELAY.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_next = S_SEND;
      S_SEND:  if (tx.tready && w_last) w_next = (PACKET_DELAY > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (r_gap <= 8'd1) w_next = (r_count != '0) ? S_SEND : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_widx <= '0;
      r_gap  <= '0;
    end else begin
      if (r_state == S_SEND && tx.tready) r_widx <= w_last ? '0 : r_widx + NW'(1);
      else if (r_state != S_SEND)         r_widx <= '0;
      if (w_pop)                                     r_gap <= 8'(PACKET_DELAY);
      else if (r_state == S_GAP && r_gap != 8'd0)    r_gap <= r_gap - 8'd1;
    end
  end

  assign tx.tvalid = (r_state == S_SEND);
  assign tx.tlast  = (r_state == S_SEND) && w_last;
  assign tx.tdata  = (r_state == S_SEND) ? w_word : 32'd0;
endmodule
`default_nettype wire
